operand_memory: RTL

OPERAND_MEMORY -- requirements
Module: operand_memory

---
 rtl/operand_memory.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/operand_memory.sv
`default_nettype none
// ============================================================================
// Module   : operand_memory
// Purpose  : Dual-read / single-write operand store. After reset the array is
//            filled with an arithmetic sequence (one entry per clock) and
//            only then are user reads and writes accepted.
//
// Ports    : clk      in   clock, all state updates on the rising edge
//            rst_n    in   asynchronous active-low reset
//            rd_en    in   read request for both read ports
//            rd_addr1 in   operand-1 read address   [ADDR_W-1:0]
//            rd_addr2 in   operand-2 read address   [ADDR_W-1:0]
//            rd_valid out  one-cycle pulse, rd_data1/rd_data2 are valid
//            rd_data1 out  operand-1 read data (registered) [DATA_W-1:0]
//            rd_data2 out  operand-2 read data (registered) [DATA_W-1:0]
//            wr_en    in   write strobe
//            wr_addr  in   write address            [ADDR_W-1:0]
//            wr_data  in   write data               [DATA_W-1:0]
//            ready    out  1 = init sequence complete, accesses accepted
//
// Config   : OPERAND_MEMORY_BYPASS_EN defined   -> read/write collision on
//            the same address returns wr_data (write-first).
//            OPERAND_MEMORY_BYPASS_EN undefined -> collision returns the
//            pre-write entry (read-first); the write still lands.
//
// Revision : 1.0 - initial release
// ============================================================================
module operand_memory #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter     INIT_SEED = 16'hA935,
    parameter     INIT_STEP = 16'h1F3D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] C_SEED     = DATA_W'(INIT_SEED);
    localparam logic [DATA_W-1:0] C_STEP     = DATA_W'(INIT_STEP);
    localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    // Running value of the init sequence; replaces a ptr*STEP multiplier.
    logic [DATA_W-1:0] r_init_val;

    logic              w_init_we;
    logic              w_user_we;
    logic              w_rd_accept;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_rd_word1;
    logic [DATA_W-1:0] w_rd_word2;

    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;

    // ------------------------------------------------------------------
    // FSM state register plus init pointer / sequence accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_ptr      <= '0;
            r_init_val <= C_SEED;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_ptr      <= r_ptr + C_PTR_ONE;
                r_init_val <= r_init_val + C_STEP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and access qualification. User strobes are gated here so
    // nothing issued during INIT can reach the array or the read pipeline.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_init_we   = 1'b0;
        w_user_we   = 1'b0;
        w_rd_accept = 1'b0;
        if (r_state == ST_INIT) begin
            w_init_we = 1'b1;
            // Leave INIT on the same edge that loads the last entry.
            if (r_ptr == C_LAST_PTR) begin
                w_state_nxt = ST_RUN;
            end
        end else begin
            w_user_we   = wr_en;
            w_rd_accept = rd_en;
        end
    end

    // ------------------------------------------------------------------
    // Storage array: no reset, contents are rebuilt by the INIT sweep.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[r_ptr] <= r_init_val;
        end else if (w_user_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read word selection (collision behaviour depends on build option)
    // ------------------------------------------------------------------
`ifdef OPERAND_MEMORY_BYPASS_EN
    assign w_rd_word1 = (w_user_we && (wr_addr == rd_addr1)) ? wr_data : r_mem[rd_addr1];
    assign w_rd_word2 = (w_user_we && (wr_addr == rd_addr2)) ? wr_data : r_mem[rd_addr2];
`else
    assign w_rd_word1 = r_mem[rd_addr1];
    assign w_rd_word2 = r_mem[rd_addr2];
`endif

    // ------------------------------------------------------------------
    // Registered read port: data holds its value between accepted reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data1 <= w_rd_word1;
                r_rd_data2 <= w_rd_word2;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data1 = r_rd_data1;
    assign rd_data2 = r_rd_data2;
    assign ready    = (r_state == ST_RUN);

endmodule
`default_nettype wire
